mm_job_arbiter: RTL and testbench
=================================

MM_JOB_ARBITER -- requirements
Module: mm_job_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one matrix-multiply engine; legal range 2..4.
REQ-002 Parameter TIMEOUT, default 1024: WAIT-state cycle budget before abort; legal range 2..65535.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NREQ  per-requester job request; a requester holds its bit high until its grant bit is seen high.
REQ-006 req_addr  input  32*NREQ  per-requester operand base address; slice i is bits [32*i+31:32*i].
REQ-007 req_mode  input  NREQ  per-requester engine mode bit.
REQ-008 grant  output  NREQ  one-hot owner indication; all zero when no job is owned.
REQ-009 done  output  NREQ  one-cycle completion pulse to the owner.
REQ-010 err  output  NREQ  one-cycle timeout pulse to the owner.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 owner_id  output  2  index of the current or most recent owner.
REQ-013 mm_start  output  1  engine start strobe.
REQ-014 mm_address  output  32  engine base address.
REQ-015 mm_mode  output  1  engine mode.
REQ-016 mm_done  input  1  engine completion level; may stay high for several cycles.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT, DRAIN; every output SHALL be registered.
REQ-018 In IDLE with any req bit high, the block SHALL select the first set bit searching upward from (ptr+1) mod NREQ with wrap, latch its index, req_addr slice and req_mode, and enter ISSUE next cycle.
REQ-019 In IDLE with req all zero, the block SHALL remain in IDLE.
REQ-020 In ISSUE, the block SHALL drive mm_start=1 for exactly one cycle and grant[owner]=1, then enter WAIT.
REQ-021 mm_address and mm_mode SHALL equal the latched values from ISSUE through DRAIN and SHALL hold them afterward until the next ISSUE.
REQ-022 grant[owner] SHALL be high in ISSUE and WAIT only; mm_start SHALL be zero outside ISSUE.
REQ-023 In WAIT, a 16-bit watchdog SHALL count from 0, incrementing each cycle.
REQ-024 In WAIT with mm_done=1, the block SHALL pulse done[owner] for one cycle in the first DRAIN cycle, set ptr=owner and enter DRAIN.
REQ-025 In WAIT with mm_done=0 and watchdog = TIMEOUT-1, the block SHALL pulse err[owner] for one cycle in the first DRAIN cycle, set ptr=owner and enter DRAIN.
REQ-026 When mm_done=1 and the timeout condition occur in the same cycle, the block SHALL pulse done only.
REQ-027 DRAIN SHALL persist while mm_done=1 and SHALL return to IDLE on the first cycle mm_done=0, which prevents a held-high done from completing the next job.
REQ-028 A req bit that falls before grant SHALL NOT be serviced; a req change after grant SHALL NOT affect the active job.
REQ-029 At most one bit of grant, done and err SHALL be high at any time; done and err SHALL never be high together.
REQ-030 Minimum request-to-start latency SHALL be 1 cycle: req sampled in IDLE at edge k gives mm_start high in cycle k+1.

Reset
REQ-031 rst SHALL force state=IDLE, ptr=NREQ-1 (requester 0 has first priority), watchdog=0, and grant=done=err=0, busy=0, owner_id=0, mm_start=0, mm_address=0, mm_mode=0.
REQ-032 rst during ISSUE, WAIT or DRAIN SHALL abort the job with no done or err pulse; arbitration SHALL restart from the reset priority.

Verification
REQ-033 After reset, req=4'b0001, addr0=0x100, mode0=1 -> next cycle: mm_start=1, grant=0001, mm_address=0x100, mm_mode=1; mm_done high at WAIT cycle 5 -> done=0001 pulse for 1 cycle, busy low once mm_done falls.
REQ-034 req=4'b1111 held, each job completed -> grant order 0,1,2,3,0.
REQ-035 TIMEOUT=8, mm_done held 0 -> err[owner] pulse after exactly 8 WAIT cycles, no done pulse, FSM back in IDLE.
REQ-036 mm_done held high for 4 cycles, req1 pending -> one done pulse, FSM stays in DRAIN until mm_done=0, then req1 receives ISSUE.
REQ-037 rst asserted in WAIT -> next cycle all outputs at reset values; no done or err pulse.
REQ-038 mm_done=1 coincides with watchdog=TIMEOUT-1 -> done pulse only, err stays 0.

Source files
------------

// File: rtl/mm_job_arbiter.sv
// mm_job_arbiter: shares one matrix-multiply engine among NREQ requesters.
// Round-robin pick in IDLE, one-cycle start strobe in ISSUE, watchdog-guarded
// WAIT, and a DRAIN state that absorbs a completion level held high.
// Every output is a flop computed from the next-state decision.
module mm_job_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_addr,
    input  logic [NREQ-1:0]      req_mode,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic                 busy,
    output logic [1:0]           owner_id,
    output logic                 mm_start,
    output logic [31:0]          mm_address,
    output logic                 mm_mode,
    input  logic                 mm_done
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_ISSUE = 2'd1;
    localparam logic [1:0]  ST_WAIT  = 2'd2;
    localparam logic [1:0]  ST_DRAIN = 2'd3;

    localparam logic [1:0]  PTR_RST  = 2'(NREQ - 1);
    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);

    // One-hot decode of a requester index.
    function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
        logic [NREQ-1:0] r;
        r      = {NREQ{1'b0}};
        r[idx] = 1'b1;
        return r;
    endfunction

    logic [1:0]      state_q,    state_d;
    logic [1:0]      ptr_q,      ptr_d;
    logic [15:0]     wd_q,       wd_d;
    logic [1:0]      owner_q,    owner_d;
    logic [31:0]     addr_q,     addr_d;
    logic            mode_q,     mode_d;
    logic [NREQ-1:0] grant_q,    grant_d;
    logic [NREQ-1:0] done_q,     done_d;
    logic [NREQ-1:0] err_q,      err_d;
    logic            busy_q,     busy_d;
    logic            start_q,    start_d;

    logic            found_s;
    logic [1:0]      pick_s;
    logic [1:0]      cand_s;

    // Round-robin search: first set req bit starting just above the pointer.
    always_comb begin
        found_s = 1'b0;
        pick_s  = 2'd0;
        cand_s  = 2'd0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_s = 2'((int'(ptr_q) + i) % NREQ);
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                pick_s  = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state, job latch, watchdog and registered-output decisions.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        mode_d  = mode_q;
        done_d  = {NREQ{1'b0}};
        err_d   = {NREQ{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d = ST_ISSUE;
                    owner_d = pick_s;
                    addr_d  = req_addr[{pick_s, 5'b00000} +: 32];
                    mode_d  = req_mode[pick_s];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                wd_d    = 16'd0;
            end
            ST_WAIT: begin
                // Completion wins over a same-cycle timeout.
                if (mm_done) begin
                    done_d  = onehot(owner_q);
                    ptr_d   = owner_q;
                    state_d = ST_DRAIN;
                end else if (wd_q == WD_LAST) begin
                    err_d   = onehot(owner_q);
                    ptr_d   = owner_q;
                    state_d = ST_DRAIN;
                end else begin
                    wd_d    = wd_q + 16'd1;
                end
            end
            ST_DRAIN: begin
                // Hold here until the engine drops its done level so it
                // cannot be mistaken for completion of the next job.
                if (mm_done) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == ST_ISSUE) || (state_d == ST_WAIT)) begin
            grant_d = onehot(owner_d);
        end else begin
            grant_d = {NREQ{1'b0}};
        end
        start_d = (state_d == ST_ISSUE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_RST;
            wd_q    <= 16'd0;
            owner_q <= 2'd0;
            addr_q  <= 32'd0;
            mode_q  <= 1'b0;
            grant_q <= {NREQ{1'b0}};
            done_q  <= {NREQ{1'b0}};
            err_q   <= {NREQ{1'b0}};
            busy_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            start_q <= start_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign owner_id   = owner_q;
    assign mm_start   = start_q;
    assign mm_address = addr_q;
    assign mm_mode    = mode_q;

endmodule

// File: tb/tb_mm_job_arbiter.sv
// Directed bench for mm_job_arbiter: cycle-by-cycle vector table plus a
// round-robin sequence with held requests.
module tb_mm_job_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] req_addr;
    logic [3:0]   req_mode;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic [3:0]   err;
    logic         busy;
    logic [1:0]   owner_id;
    logic         mm_start;
    logic [31:0]  mm_address;
    logic         mm_mode;
    logic         mm_done;

    int checks = 0;
    int errors = 0;

    mm_job_arbiter #(.NREQ(4), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_addr   (req_addr),
        .req_mode   (req_mode),
        .grant      (grant),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .owner_id   (owner_id),
        .mm_start   (mm_start),
        .mm_address (mm_address),
        .mm_mode    (mm_mode),
        .mm_done    (mm_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [3:0]  req;
        logic        md;
        logic [3:0]  g;
        logic [3:0]  d;
        logic [3:0]  e;
        logic        busy;
        logic [1:0]  own;
        logic        st;
        logic [31:0] addr;
        logic        mode;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic m,
                                input logic [3:0] g, input logic [3:0] d, input logic [3:0] e,
                                input logic b, input logic [1:0] o, input logic s,
                                input logic [31:0] a, input logic md_);
        vec_t v;
        v.rst = r;  v.req = rq; v.md = m;  v.g = g; v.d = d; v.e = e;
        v.busy = b; v.own = o;  v.st = s;  v.addr = a; v.mode = md_;
        return v;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_row(input int idx, input vec_t v);
        logic [48:0] act;
        logic [48:0] exp;
        act = {grant, done, err, busy, owner_id, mm_start, mm_address, mm_mode};
        exp = {v.g, v.d, v.e, v.busy, v.own, v.st, v.addr, v.mode};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row%0d {grant,done,err,busy,own,start,addr,mode} actual=%h required=%h",
                     idx, act, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_g;
        int         cyc;

        req_addr = {32'h0000_0400, 32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        req_mode = 4'b0101;
        rst      = 1'b1;
        req      = 4'b0000;
        mm_done  = 1'b0;

        // r  req    md    g      d      e      b     own   st    addr          mode
        vt.push_back(mk(1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 32'h000, 1'b0));
        // single job, completion at WAIT cycle 5
        vt.push_back(mk(1'b0, 4'h1, 1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 2'd0, 1'b1, 32'h100, 1'b1));
        for (int i = 0; i < 5; i++)
            vt.push_back(mk(1'b0, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 2'd0, 1'b0, 32'h100, 1'b1));
        vt.push_back(mk(1'b0, 4'h0, 1'b1, 4'h0, 4'h1, 4'h0, 1'b1, 2'd0, 1'b0, 32'h100, 1'b1));
        vt.push_back(mk(1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 2'd0, 1'b0, 32'h100, 1'b1));
        vt.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 32'h100, 1'b1));
        // job 0 again; req2 rises then falls while busy; done held 4 cycles with req1 pending
        vt.push_back(mk(1'b0, 4'h1, 1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 2'd0, 1'b1, 32'h100, 1'b1));
        vt.push_back(mk(1'b0, 4'h4, 1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 2'd0, 1'b0, 32'h100, 1'b1));
        vt.push_back(mk(1'b0, 4'h0, 1'b1, 4'h0, 4'h1, 4'h0, 1'b1, 2'd0, 1'b0, 32'h100, 1'b1));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(1'b0, 4'h2, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 2'd0, 1'b0, 32'h100, 1'b1));
        vt.push_back(mk(1'b0, 4'h2, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 32'h100, 1'b1));
        // req1 issued, then times out after 8 WAIT cycles
        vt.push_back(mk(1'b0, 4'h2, 1'b0, 4'h2, 4'h0, 4'h0, 1'b1, 2'd1, 1'b1, 32'h200, 1'b0));
        for (int i = 0; i < 8; i++)
            vt.push_back(mk(1'b0, 4'h0, 1'b0, 4'h2, 4'h0, 4'h0, 1'b1, 2'd1, 1'b0, 32'h200, 1'b0));
        vt.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h2, 1'b1, 2'd1, 1'b0, 32'h200, 1'b0));
        vt.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd1, 1'b0, 32'h200, 1'b0));
        // done coincides with the last watchdog count: done only
        vt.push_back(mk(1'b0, 4'h1, 1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 2'd0, 1'b1, 32'h100, 1'b1));
        for (int i = 0; i < 8; i++)
            vt.push_back(mk(1'b0, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 2'd0, 1'b0, 32'h100, 1'b1));
        vt.push_back(mk(1'b0, 4'h0, 1'b1, 4'h0, 4'h1, 4'h0, 1'b1, 2'd0, 1'b0, 32'h100, 1'b1));
        vt.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 32'h100, 1'b1));
        // reset in WAIT aborts silently and restores requester-0 priority
        vt.push_back(mk(1'b0, 4'h8, 1'b0, 4'h8, 4'h0, 4'h0, 1'b1, 2'd3, 1'b1, 32'h400, 1'b0));
        vt.push_back(mk(1'b0, 4'h0, 1'b0, 4'h8, 4'h0, 4'h0, 1'b1, 2'd3, 1'b0, 32'h400, 1'b0));
        vt.push_back(mk(1'b1, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 32'h000, 1'b0));
        vt.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 32'h000, 1'b0));
        vt.push_back(mk(1'b0, 4'h9, 1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 2'd0, 1'b1, 32'h100, 1'b1));

        for (int i = 0; i < vt.size(); i++) begin
            rst     = vt[i].rst;
            req     = vt[i].req;
            mm_done = vt[i].md;
            step();
            check_row(i, vt[i]);
        end

        // Round robin with all requests held: expected owners 0,1,2,3,0.
        rst = 1'b1; req = 4'h0; mm_done = 1'b0;
        step();
        rst = 1'b0; req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            cyc = 0;
            while (mm_start !== 1'b1 && cyc < 20) begin
                step();
                cyc++;
            end
            exp_g = 4'b0001 << (k % 4);
            checks++;
            if (cyc >= 20) begin
                errors++;
                $display("FAIL rr_timeout job%0d mm_start actual=%b required=1", k, mm_start);
            end else if (grant !== exp_g) begin
                errors++;
                $display("FAIL rr_grant job%0d actual=%b required=%b", k, grant, exp_g);
            end
            mm_done = 1'b1;
            step();
            step();
            mm_done = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
